// File: rtl/div_stall_unit_pkg.sv
// Shared definitions for the multi-cycle divider: datapath width, FSM encoding
// and the architected divide-by-zero quotient.
package div_stall_unit_pkg;

    localparam int DATA_W  = 32;
    localparam int COUNT_W = $clog2(DATA_W);

    localparam logic [COUNT_W-1:0] LAST_STEP         = COUNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]  DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Two's-complement magnitude, only when the operand is treated as signed.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                    input logic            is_signed);
        return (is_signed && value[DATA_W-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/div_stall_unit_iter_step.sv
// One restoring radix-2 division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_iter_step
    import div_stall_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic              next_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // The partial remainder is always below the divisor, so one extra bit
    // holds the shifted value and the borrow of the trial subtraction.
    always_comb begin
        shifted = {rem_in, next_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[DATA_W];
        rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/div_stall_unit.sv
// Iterative 32-bit divider for the EX stage: holds the pipeline through
// stall_request until the quotient/remainder are ready.
module div_stall_unit
    import div_stall_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              div_en,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              stall_request,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi,
    output logic              done
);

    div_state_e         state;
    logic [COUNT_W-1:0] count;
    logic [DATA_W-1:0]  rem_q;
    logic [DATA_W-1:0]  quot_q;
    logic [DATA_W-1:0]  divisor_q;
    logic               neg_quot;
    logic               neg_rem;

    logic [DATA_W-1:0]  step_rem;
    logic               step_bit;
    logic [DATA_W-1:0]  quot_next;

    div_iter_step u_step (
        .rem_in   (rem_q),
        .next_bit (quot_q[DATA_W-1]),
        .divisor  (divisor_q),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    assign quot_next = {quot_q[DATA_W-2:0], step_bit};

    // The stall must reach the pipeline controller in the issue cycle itself,
    // so it is decoded from the current state rather than registered.
    assign stall_request = div_en && (state != ST_DONE) && !flush && !rst;

    // quot_q doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            done      <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_en) begin
                        if (operand_b != '0) begin
                            quot_q    <= magnitude(operand_a, div_signed);
                            divisor_q <= magnitude(operand_b, div_signed);
                            rem_q     <= '0;
                            count     <= '0;
                            neg_quot  <= div_signed && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
                            neg_rem   <= div_signed && operand_a[DATA_W-1];
                            state     <= ST_BUSY;
                        end else begin
                            result_lo <= DIV_ZERO_QUOTIENT;
                            result_hi <= operand_a;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    rem_q  <= step_rem;
                    quot_q <= quot_next;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        // Sign fix-up happens once, on the final step's outputs.
                        result_lo <= neg_quot ? (~quot_next + 1'b1) : quot_next;
                        result_hi <= neg_rem  ? (~step_rem + 1'b1)  : step_rem;
                        done      <= 1'b1;
                        count     <= '0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_stall_unit.md
DIV_STALL_UNIT -- requirements
Module: div_stall_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 div_en  in  1  EX stage holds a divide instruction this cycle.
REQ-004 div_signed  in  1  1 = signed divide, 0 = unsigned; sampled at start.
REQ-005 operand_a  in  32  dividend; sampled at start.
REQ-006 operand_b  in  32  divisor; sampled at start.
REQ-007 flush  in  1  cancel any in-flight divide.
REQ-008 stall_request  out  1  drives request_from_ex of the pipeline controller.
REQ-009 result_lo  out  32  quotient.
REQ-010 result_hi  out  32  remainder.
REQ-011 done  out  1  result_lo/result_hi valid this cycle.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; encoding from shared package.
REQ-013 In IDLE with div_en=1 and flush=0: stall_request=1 combinationally that same cycle; latch operands and sign mode; operand_b!=0 -> BUSY with iteration count=0; operand_b==0 -> DONE.
REQ-014 In BUSY: one restoring radix-2 step per cycle on absolute values; stall_request=1; count 0..31; after step 31 -> DONE.
REQ-015 In DONE: stall_request=0, done=1, results held; next edge -> IDLE unconditionally.
REQ-016 Latency: issue cycle plus 32 BUSY cycles = 33 stalled cycles; done asserted in cycle 34.
REQ-017 stall_request = div_en AND (state!=DONE) AND NOT flush; it is never asserted in DONE, even if div_en remains high.
REQ-018 Signed mode: dividend and divisor converted to magnitude; quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-019 Unsigned mode: no conversion; full 32-bit magnitudes.
REQ-020 Divide by zero: result_lo=32'hFFFF_FFFF, result_hi=latched operand_a, done in cycle 2, 1 stalled cycle.
REQ-021 Signed overflow (32'h8000_0000 / 32'hFFFF_FFFF): result_lo=32'h8000_0000, result_hi=0, normal 33-cycle latency.
REQ-022 flush=1 in any state: stall_request=0 the same cycle; next state IDLE; done=0; partial results discarded.
REQ-023 div_en dropping while BUSY (without flush) does not abort; the FSM completes and reaches DONE.
REQ-024 Results remain stable in IDLE until the next start; done=1 only in DONE.

Reset
REQ-025 rst=1 forces IDLE asynchronously; stall_request=0, done=0, result_lo=0, result_hi=0, count=0.
REQ-026 Reset mid-BUSY abandons the divide; after release, the unit accepts a new start in the first cycle.

Structure
REQ-027 Shared package holds DATA_W=32, the FSM state typedef/encoding, and the DIV_ZERO_QUOTIENT constant.
REQ-028 One sub-module, div_iter_step: combinational single restoring step (partial remainder, quotient bit); instantiated once.
REQ-029 Sign conversion and final negation are implemented in div_stall_unit, not in div_iter_step.

Verification
REQ-030 Unsigned 100/7 -> stall_request high for 33 cycles; done in cycle 34 with result_lo=14, result_hi=2.
REQ-031 Signed -7/2 (32'hFFFF_FFF9 / 2) -> result_lo=32'hFFFF_FFFD, result_hi=32'hFFFF_FFFF; signed 7/-2 -> result_lo=32'hFFFF_FFFD, result_hi=1.
REQ-032 Divide by zero (5/0) -> one stalled cycle; result_lo=32'hFFFF_FFFF, result_hi=5; signed 32'h8000_0000 / -1 -> result_lo=32'h8000_0000, result_hi=0.
REQ-033 flush at BUSY count=10 -> stall_request=0 the same cycle, IDLE next cycle, done never asserted; a new 9/3 then yields result_lo=3, result_hi=0.
REQ-034 rst pulse at BUSY count=20 -> all outputs 0 immediately; back-to-back divides 20/3 then 8/8 -> second start taken the cycle after DONE, results 6/2 then 1/0.
